// File: rtl/adc_capture_ctrl.sv
// Acquisition sequencer for the dual-channel ADC path: arm, trigger, decimate and
// write one fixed-length record into a single-port sample RAM.
module adc_capture_ctrl #(
  parameter int DATA_W  = 14,
  parameter int ADDR_W  = 10,
  parameter int DECIM_W = 8
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     chan_sel,
  input  logic                     trig_mode,
  input  logic signed [DATA_W-1:0] trig_level,
  input  logic [DECIM_W-1:0]       decim,
  input  logic [ADDR_W-1:0]        len_m1,
  input  logic signed [DATA_W-1:0] a2da_data,
  input  logic signed [DATA_W-1:0] a2db_data,
  input  logic                     ada_or,
  input  logic                     adb_or,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic                     busy,
  output logic                     done,
  output logic                     or_flag
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_TRIG, S_CAPTURE, S_DONE} state_t;

  state_t                     state;
  logic                       lat_chan;
  logic                       lat_mode;
  logic signed [DATA_W-1:0]   lat_level;
  logic [DECIM_W-1:0]         lat_decim;
  logic [ADDR_W-1:0]          lat_len;
  logic [DECIM_W-1:0]         dcnt;
  logic signed [DATA_W-1:0]   prev_data;
  logic                       prev_vld;

  logic signed [DATA_W-1:0]   cur_data;
  logic                       cur_or;
  logic                       trig_hit;
  logic [ADDR_W-1:0]          next_addr;

  // Channel choice comes from the latched select so mid-record input changes are ignored.
  always_comb begin
    cur_data  = lat_chan ? a2db_data : a2da_data;
    cur_or    = lat_chan ? adb_or : ada_or;
    trig_hit  = lat_mode ? (prev_vld && (prev_data < lat_level) && (cur_data >= lat_level))
                         : 1'b1;
    next_addr = wr_addr + 1'b1;
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      lat_chan  <= 1'b0;
      lat_mode  <= 1'b0;
      lat_level <= '0;
      lat_decim <= '0;
      lat_len   <= '0;
      dcnt      <= '0;
      prev_data <= '0;
      prev_vld  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      or_flag   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              lat_chan  <= chan_sel;
              lat_mode  <= trig_mode;
              lat_level <= trig_level;
              lat_decim <= decim;
              lat_len   <= len_m1;
              prev_vld  <= 1'b0;
              wr_addr   <= '0;
              or_flag   <= 1'b0;
              done      <= 1'b0;
              busy      <= 1'b1;
              state     <= S_WAIT_TRIG;
            end
          end
          S_WAIT_TRIG: begin
            prev_data <= cur_data;
            prev_vld  <= 1'b1;
            if (trig_hit) begin
              wr_en   <= 1'b1;
              wr_addr <= '0;
              wr_data <= cur_data;
              or_flag <= or_flag | cur_or;
              dcnt    <= lat_decim;
              if (lat_len == '0) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                state <= S_CAPTURE;
              end
            end
          end
          S_CAPTURE: begin
            if (dcnt == '0) begin
              wr_en   <= 1'b1;
              wr_addr <= next_addr;
              wr_data <= cur_data;
              or_flag <= or_flag | cur_or;
              dcnt    <= lat_decim;
              if (next_addr == lat_len) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end
            end else begin
              dcnt <= dcnt - 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: directed and randomized records checked against a
// record-level model computed from the recorded sample history.
module tb_adc_capture_ctrl;
  localparam int DW = 14, AW = 10, DCW = 8, HN = 16384;

  logic sys_clk = 1'b0, reset;
  logic start, abort, chan_sel, trig_mode;
  logic [DW-1:0] trig_level, a2da_data, a2db_data;
  logic [DCW-1:0] decim;
  logic [AW-1:0] len_m1;
  logic ada_or, adb_or;
  logic wr_en, busy, done, or_flag;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  adc_capture_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DECIM_W(DCW)) dut (
    .sys_clk(sys_clk), .reset(reset), .start(start), .abort(abort),
    .chan_sel(chan_sel), .trig_mode(trig_mode), .trig_level(trig_level),
    .decim(decim), .len_m1(len_m1), .a2da_data(a2da_data), .a2db_data(a2db_data),
    .ada_or(ada_or), .adb_or(adb_or), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .or_flag(or_flag));

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    int            c;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          dn;
    logic          bs;
  } wr_t;

  typedef struct {
    logic           ch;
    logic           md;
    logic [DW-1:0]  lvl;
    logic [DCW-1:0] dc;
    logic [AW-1:0]  ln;
  } cfg_t;

  wr_t obs[$];
  always @(negedge sys_clk) if (wr_en === 1'b1) obs.push_back('{cyc, wr_addr, wr_data, done, busy});

  // Sample history indexed by absolute cycle, and stimulus for the upcoming record.
  logic [DW-1:0] ha[HN], hb[HN];
  logic          haor[HN], hbor[HN];
  logic [DW-1:0] pa[256], pb[256];
  logic          paor[256], pbor[256];

  int n_chk = 0, n_fail = 0;

  task automatic step(input logic st, input logic ab, input cfg_t c,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic ao, input logic bo);
    @(negedge sys_clk);
    start = st; abort = ab;
    chan_sel = c.ch; trig_mode = c.md; trig_level = c.lvl; decim = c.dc; len_m1 = c.ln;
    a2da_data = a; a2db_data = b; ada_or = ao; adb_or = bo;
    ha[cyc % HN] = a; hb[cyc % HN] = b; haor[cyc % HN] = ao; hbor[cyc % HN] = bo;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.ch  = 1'($urandom_range(0, 1));
    c.md  = 1'($urandom_range(0, 1));
    c.lvl = DW'(int'($urandom_range(0, 8)) - 4);
    c.dc  = DCW'($urandom_range(0, 3));
    c.ln  = AW'($urandom_range(0, 7));
    return c;
  endfunction

  task automatic fill(input int lo, input int hi);
    for (int i = 0; i < 256; i++) begin
      pa[i]   = DW'(lo + int'($urandom_range(0, hi - lo)));
      pb[i]   = DW'(lo + int'($urandom_range(0, hi - lo)));
      paor[i] = ($urandom_range(0, 7) == 0);
      pbor[i] = ($urandom_range(0, 7) == 0);
    end
  endtask

  function automatic logic [DW-1:0] sel(input logic ch, input int x);
    return ch ? hb[x % HN] : ha[x % HN];
  endfunction

  function automatic logic sel_or(input logic ch, input int x);
    return ch ? hbor[x % HN] : haor[x % HN];
  endfunction

  // Plays one record and checks it: expected writes come from the trigger rule plus
  // write k at T+1+k*(decim+1) carrying sample(T+k*(decim+1)).
  task automatic run_record(input cfg_t c, input int win, input bit scr,
                            input int abort_at, input int restart_at, input string tag);
    int s, e, lim, t, wc, n;
    bit found, full, aborted;
    logic exp_or, exp_done, exp_busy;
    wr_t ex[$], got[$];
    obs.delete();
    step(1'b1, 1'b0, c, pa[0], pb[0], paor[0], pbor[0]);
    s = cyc;
    for (int i = 1; i < win; i++)
      step(i == restart_at, i == abort_at, scr ? rand_cfg() : c, pa[i], pb[i], paor[i], pbor[i]);
    @(negedge sys_clk); #1;
    e = cyc;
    aborted = (abort_at >= 0);
    lim = aborted ? ((s + abort_at < e) ? s + abort_at : e) : e;
    found = 0; t = 0;
    if (!c.md) begin
      t = s + 1; found = (t + 1 <= lim);
    end else begin
      for (int x = s + 2; x + 1 <= lim && !found; x++)
        if ($signed(sel(c.ch, x - 1)) < $signed(c.lvl) && $signed(sel(c.ch, x)) >= $signed(c.lvl)) begin
          found = 1; t = x;
        end
    end
    full = 0; exp_or = 0;
    if (found)
      for (int k = 0; k <= int'(c.ln); k++) begin
        wc = t + 1 + k * (int'(c.dc) + 1);
        if (wc <= lim) begin
          ex.push_back('{wc, AW'(k), sel(c.ch, wc - 1), k == int'(c.ln), k != int'(c.ln)});
          exp_or |= sel_or(c.ch, wc - 1);
          if (k == int'(c.ln)) full = 1;
        end
      end
    exp_done = full && !aborted;
    exp_busy = !full && !aborted;
    foreach (obs[i]) if (obs[i].c >= s && obs[i].c <= e) got.push_back(obs[i]);

    n_chk++;
    if (got.size() !== ex.size()) begin
      n_fail++; $display("FAIL %s write_count: got %0d want %0d", tag, got.size(), ex.size());
    end
    n = (got.size() < ex.size()) ? got.size() : ex.size();
    for (int i = 0; i < n; i++) begin
      n_chk++;
      if (got[i].c !== ex[i].c) begin
        n_fail++; $display("FAIL %s wr%0d_cycle: got S+%0d want S+%0d", tag, i, got[i].c - s, ex[i].c - s);
      end
      n_chk++;
      if (got[i].addr !== ex[i].addr) begin
        n_fail++; $display("FAIL %s wr%0d_addr: got %0d want %0d", tag, i, got[i].addr, ex[i].addr);
      end
      n_chk++;
      if (got[i].data !== ex[i].data) begin
        n_fail++; $display("FAIL %s wr%0d_data: got %0d want %0d", tag, i, $signed(got[i].data), $signed(ex[i].data));
      end
      n_chk++;
      if ({got[i].dn, got[i].bs} !== {ex[i].dn, ex[i].bs}) begin
        n_fail++; $display("FAIL %s wr%0d_done_busy: got %b%b want %b%b", tag, i, got[i].dn, got[i].bs, ex[i].dn, ex[i].bs);
      end
    end
    n_chk++;
    if ({busy, done} !== {exp_busy, exp_done}) begin
      n_fail++; $display("FAIL %s end_busy_done: got %b%b want %b%b", tag, busy, done, exp_busy, exp_done);
    end
    n_chk++;
    if (or_flag !== exp_or) begin
      n_fail++; $display("FAIL %s or_flag: got %b want %b", tag, or_flag, exp_or);
    end
    // A record left armed must be cleared so the next start is accepted.
    if (!exp_done) begin
      step(1'b0, 1'b1, c, '0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b0, c, '0, '0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    cfg_t c;
    c = '{1'b0, 1'b0, '0, '0, '0};
    reset = 1'b1;
    step(1'b0, 1'b0, c, '0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, c, '0, '0, 1'b0, 1'b0);
    n_chk++;
    if ({wr_en, busy, done, or_flag} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {wr_en, busy, done, or_flag});
    end
    n_chk++;
    if ({wr_addr, wr_data} !== '0) begin
      n_fail++; $display("FAIL reset_addr_data: got %0d/%0d want 0/0", wr_addr, wr_data);
    end
    reset = 1'b0;
    step(1'b0, 1'b0, c, '0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, c, '0, '0, 1'b0, 1'b0);
    n_chk++;
    if ({wr_en, busy, done} !== 3'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b want 000", {wr_en, busy, done});
    end
  endtask

  task automatic test_immediate();
    cfg_t c;
    c = '{1'b0, 1'b0, '0, 8'd0, 10'd3};
    fill(-500, 500);
    for (int i = 0; i < 256; i++) pa[i] = DW'(100 + i);
    run_record(c, 8, 1'b1, -1, -1, "immediate");
  endtask

  task automatic test_decim();
    cfg_t c;
    c = '{1'b1, 1'b0, '0, 8'd2, 10'd2};
    fill(-500, 500);
    for (int i = 0; i < 256; i++) pb[i] = DW'(200 + i);
    run_record(c, 12, 1'b1, -1, -1, "decim");
  endtask

  task automatic test_level();
    cfg_t c;
    c = '{1'b0, 1'b1, '0, 8'd0, 10'd3};
    fill(-8, 8);
    pa[0] = -14'sd5; pa[1] = -14'sd5; pa[2] = -14'sd1; pa[3] = 14'd0; pa[4] = 14'd3;
    run_record(c, 12, 1'b0, -1, -1, "level_cross");
    // Positive from the first armed cycle: no valid previous sample, so no crossing.
    fill(-8, 8);
    pa[0] = -14'sd5;
    for (int i = 1; i < 256; i++) pa[i] = DW'(3 + int'($urandom_range(0, 100)));
    run_record(c, 20, 1'b0, -1, -1, "level_never");
  endtask

  task automatic test_or();
    cfg_t c;
    c = '{1'b1, 1'b0, '0, 8'd1, 10'd3};
    fill(-100, 100);
    for (int i = 0; i < 256; i++) begin pbor[i] = 1'b0; paor[i] = 1'b1; end
    pbor[3] = 1'b1;
    run_record(c, 12, 1'b0, -1, -1, "or_set");
    for (int i = 0; i < 256; i++) pbor[i] = 1'b0;
    pbor[2] = 1'b1;
    run_record(c, 12, 1'b0, -1, -1, "or_clear");
  endtask

  task automatic test_abort();
    cfg_t c;
    c = '{1'b0, 1'b0, '0, 8'd0, 10'd7};
    fill(-300, 300);
    run_record(c, 4, 1'b0, 3, -1, "abort_2nd");
    fill(-300, 300);
    run_record(c, 14, 1'b0, -1, -1, "after_abort");
    obs.delete();
    step(1'b1, 1'b1, c, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, c, '0, '0, 1'b0, 1'b0);
    #1;
    n_chk++;
    if (busy !== 1'b0 || obs.size() != 0) begin
      n_fail++; $display("FAIL start_with_abort: got busy=%b writes=%0d want busy=0 writes=0", busy, obs.size());
    end
  endtask

  task automatic test_back_to_back();
    cfg_t c;
    c = '{1'b1, 1'b0, '0, 8'd1, 10'd5};
    fill(-1000, 1000);
    run_record(c, 16, 1'b0, -1, 5, "restart_ignored");
    c = '{1'b0, 1'b0, '0, 8'd0, 10'd0};
    fill(-1000, 1000);
    run_record(c, 5, 1'b0, -1, -1, "from_done_len1");
  endtask

  task automatic test_reset_mid();
    cfg_t c;
    c = '{1'b0, 1'b0, '0, 8'd0, 10'd7};
    fill(-100, 100);
    step(1'b1, 1'b0, c, pa[0], pb[0], 1'b1, 1'b1);
    for (int i = 1; i < 4; i++) step(1'b0, 1'b0, c, pa[i], pb[i], 1'b1, 1'b1);
    #2;
    n_chk++;
    if ({busy, wr_en} !== 2'b11) begin
      n_fail++; $display("FAIL pre_reset_active: got busy/wr_en %b want 11", {busy, wr_en});
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if ({wr_en, busy, done, or_flag} !== 4'b0 || {wr_addr, wr_data} !== '0) begin
      n_fail++; $display("FAIL async_reset: got flags %b addr %0d data %0d want all 0",
                         {wr_en, busy, done, or_flag}, wr_addr, wr_data);
    end
    @(negedge sys_clk);
    reset = 1'b0;
    obs.delete();
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, c, pa[i], pb[i], 1'b0, 1'b0);
    #1;
    n_chk++;
    if (busy !== 1'b0 || obs.size() != 0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b writes=%0d want 0/0", busy, obs.size());
    end
  endtask

  task automatic test_random();
    cfg_t c;
    int win, ab;
    for (int r = 0; r < 25; r++) begin
      c = rand_cfg();
      fill(-8, 8);
      win = 6 + (int'(c.ln) + 1) * (int'(c.dc) + 1) + (c.md ? 10 : 0);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, win - 1)) : -1;
      run_record(c, win, 1'b1, ab, -1, $sformatf("rand%0d", r));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; chan_sel = 1'b0; trig_mode = 1'b0;
    trig_level = '0; decim = '0; len_m1 = '0; a2da_data = '0; a2db_data = '0;
    ada_or = 1'b0; adb_or = 1'b0;
    test_reset();
    test_immediate();
    test_decim();
    test_level();
    test_or();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
